gate_array_pipe: RTL and testbench
==================================

// Module: gate_array_pipe
// PURPOSE
//  Parametrised, pipelined N-input bitwise logic unit. Applies a selectable gate
//  function (OR/AND/XOR and their inversions, pass) across NUM_IN operands of WIDTH
//  bits, with valid/ready handshakes on both sides and a completed-transaction counter.
//  Serves as the registered, multi-mode, back-pressurable generation of the team's
//  two-input gate blocks.
// PARAMETERS
//  WIDTH   8   bits per operand and result
//  NUM_IN  4   operand count, 2..8
//  STAGES  2   pipeline register stages, 1..4 (= latency in cycles)
//  CNT_W   16  transaction counter width
// PORTS
//  clk        in   1             clock, rising edge
//  rst        in   1             synchronous reset, active-high
//  in_data    in   NUM_IN*WIDTH  operands; operand k = in_data[k*WIDTH +: WIDTH]
//  in_op      in   3             gate select, sampled with in_data
//  in_valid   in   1             input beat valid
//  in_ready   out  1             unit accepts input this cycle
//  out_data   out  WIDTH         result
//  out_err    out  1             result was produced from a reserved opcode
//  out_valid  out  1             result valid
//  out_ready  in   1             downstream accepts result
//  txn_count  out  CNT_W         number of accepted output beats, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - One clock, clk; rst is synchronous, active-high. All state is updated on the rising edge.
//  - Opcodes: 0 OR, 1 AND, 2 XOR (odd parity per bit), 3 NOR, 4 NAND, 5 XNOR, 6 PASS
//    (operand 0), 7 reserved. Opcode 7 gives out_data = 0 and out_err = 1. Every
//    other opcode gives out_err = 0.
//  - Result is computed combinationally from the input beat and in_op. It is
//    registered into stage 1 and shifted through STAGES stages. Each stage holds
//    data, err and a valid bit. out_* are driven from the last stage.
//  - Input accept: in_valid && in_ready. Output accept: out_valid && out_ready.
//  - Stall: stall = out_valid && !out_ready. in_ready = !stall, combinational.
//  - When stall = 1, no stage changes, in_ready = 0, and out_data/out_err/out_valid
//    hold stable.
//  - When stall = 0, all stages shift every cycle. Stage 1 valid = in_valid.
//  - Bubbles are not collapsed.
//  - Latency: a beat accepted on edge t appears with out_valid = 1 after edge
//    t+STAGES-1, i.e. STAGES cycles after acceptance, provided no stall occurs.
//    Full throughput is 1 beat per cycle while out_ready = 1.
//  - Data and err in invalid stages are don't-care. The reset value is still 0.
//  - txn_count increments by 1 on each output accept. It wraps from 2^CNT_W-1 to 0
//    with no flag.
//  - Reset (at any time, including mid-stall or with beats in flight):
//    - all stage valid bits, data and err are cleared to 0; txn_count is cleared to 0.
//    - After the reset edge: out_valid = 0, out_data = 0, out_err = 0,
//      in_ready = 1, txn_count = 0.
//    - In-flight beats are discarded. No input is accepted on a cycle where rst = 1.
//  - in_op is sampled only on input accept. Changing it while in_ready = 0 has no effect.
// TESTING
//  - Reset: after rst is held 2 cycles, check out_valid = 0, out_data = 0,
//    txn_count = 0, in_ready = 1.
//  - Modes (WIDTH=8, NUM_IN=4), operands {0x01,0x02,0x04,0x80}:
//    - op 0 -> 0x87; op 1 -> 0x00; op 2 -> 0x87; op 3 -> 0x78; op 4 -> 0xFF;
//      op 5 -> 0x78; op 6 -> 0x01.
//    - op 7 -> out_data = 0x00, out_err = 1.
//  - Latency and throughput (STAGES=2, out_ready = 1): drive 10 back-to-back beats.
//    - Each result appears exactly 2 cycles after its accept, in order.
//    - Afterwards txn_count = 10.
//  - Backpressure: hold out_ready = 0 for 5 cycles while out_valid = 1.
//    - out_data holds stable and in_ready = 0; no beat is lost or duplicated.
//    - Release out_ready and check the order is preserved.
//  - Reset mid-stream: assert rst while 2 beats are in flight.
//    - Next cycle out_valid = 0 and txn_count = 0; in-flight results never appear.
//  - Counter wrap (CNT_W=4): 17 accepted outputs -> txn_count = 1.

Source files
------------

// File: rtl/gate_array_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : gate_array_pipe
//  Description : Pipelined NUM_IN-operand bitwise gate unit with valid/ready
//                handshakes and a completed-output transaction counter.
//  Revision    : 1.0  initial release
// ============================================================================
module gate_array_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        txn_count
);

  localparam logic [2:0] c_op_or   = 3'd0;
  localparam logic [2:0] c_op_and  = 3'd1;
  localparam logic [2:0] c_op_xor  = 3'd2;
  localparam logic [2:0] c_op_nor  = 3'd3;
  localparam logic [2:0] c_op_nand = 3'd4;
  localparam logic [2:0] c_op_xnor = 3'd5;
  localparam logic [2:0] c_op_pass = 3'd6;

  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic             w_stall;

  logic [WIDTH-1:0] r_data  [STAGES];
  logic             r_err   [STAGES];
  logic             r_valid [STAGES];
  logic [CNT_W-1:0] r_txn;

  // Reduce all operands once; each opcode then just selects or inverts.
  always_comb begin
    w_or  = '0;
    w_and = '1;
    w_xor = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_or  = w_or  | in_data[k*WIDTH +: WIDTH];
      w_and = w_and & in_data[k*WIDTH +: WIDTH];
      w_xor = w_xor ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (in_op)
      c_op_or:   w_res = w_or;
      c_op_and:  w_res = w_and;
      c_op_xor:  w_res = w_xor;
      c_op_nor:  w_res = ~w_or;
      c_op_nand: w_res = ~w_and;
      c_op_xnor: w_res = ~w_xor;
      c_op_pass: w_res = in_data[WIDTH-1:0];
      default: begin
        w_res = '0;
        w_err = 1'b1;
      end
    endcase
  end

  assign w_stall  = r_valid[STAGES-1] && !out_ready;
  // Held low during reset so nothing is accepted on a reset cycle.
  assign in_ready = !w_stall && !rst;

  // Whole pipe advances together; bubbles travel with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_data[s]  <= '0;
        r_err[s]   <= 1'b0;
        r_valid[s] <= 1'b0;
      end
    end else if (!w_stall) begin
      r_data[0]  <= w_res;
      r_err[0]   <= w_err;
      r_valid[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        r_data[s]  <= r_data[s-1];
        r_err[s]   <= r_err[s-1];
        r_valid[s] <= r_valid[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txn <= '0;
    end else if (r_valid[STAGES-1] && out_ready) begin
      r_txn <= r_txn + CNT_W'(1);
    end
  end

  assign out_data  = r_data[STAGES-1];
  assign out_err   = r_err[STAGES-1];
  assign out_valid = r_valid[STAGES-1];
  assign txn_count = r_txn;

endmodule
`default_nettype wire

// File: tb/tb_gate_array_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_array_pipe
//  Description : Scoreboard bench for gate_array_pipe (WIDTH 8, NUM_IN 4,
//                STAGES 2, CNT_W 4) using hand-computed directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gate_array_pipe;

  localparam int c_stages = 2;
  localparam int c_cnt_w  = 4;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         lat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        in_data;
  logic [2:0]         in_op;
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         out_data;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;
  logic [c_cnt_w-1:0] txn_count;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  gate_array_pipe #(
    .WIDTH (8),
    .NUM_IN(4),
    .STAGES(c_stages),
    .CNT_W (c_cnt_w)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_op    (in_op),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Inputs are driven 1 time unit after posedge, so at negedge they equal
  // what the next posedge will sample.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_err", 32'(out_err), 32'(e.e));
        if (e.lat >= 0) chk("latency_cycle", 32'(cyc), 32'(e.lat));
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [2:0] op, input logic [7:0] ed,
                      input logic ee, input bit push, input bit chk_lat);
    bit acc;
    bit done;
    exp_t e;
    done     = 1'b0;
    in_data  = d;
    in_op    = op;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        done = 1'b1;
        if (push) begin
          e.d   = ed;
          e.e   = ee;
          e.lat = chk_lat ? cyc + c_stages - 1 : -1;
          exp_q.push_back(e);
        end
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] tp_data [10] = '{32'h08040201, 32'hF83CF0FF, 32'h000F55AA, 32'h00000000,
                                32'hFFFFFFFF, 32'h88442211, 32'h1200FF5A, 32'h78563412,
                                32'h010F0F0F, 32'hFFE7C381};
  logic [2:0]  tp_op   [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd1};
  logic [7:0]  tp_exp  [10] = '{8'h0F, 8'h30, 8'hF0, 8'hFF, 8'h00, 8'h00, 8'h5A, 8'h00,
                                8'h0E, 8'h81};
  logic [7:0]  md_exp  [8]  = '{8'h87, 8'h00, 8'h87, 8'h78, 8'hFF, 8'h78, 8'h01, 8'h00};

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_op     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset state
    tick(2);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_txn_count", 32'(txn_count), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // All opcodes on operands {0x01,0x02,0x04,0x80}
    for (int i = 0; i < 8; i++) begin
      send(32'h80040201, 3'(i), md_exp[i], (i == 7), 1'b1, 1'b0);
    end
    drain();

    // Back-to-back throughput and latency from a clean counter
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(tp_data[i], tp_op[i], tp_exp[i], (tp_op[i] == 3'd7), 1'b1, 1'b1);
    end
    drain();
    tick(2);
    chk("txn_count_after_10", 32'(txn_count), 32'd10);

    // Backpressure: two beats fill the pipe, then stall for 5 cycles
    out_ready = 1'b0;
    send(32'h08040201, 3'd0, 8'h0F, 1'b0, 1'b1, 1'b0);
    send(32'h000000C3, 3'd6, 8'hC3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data", 32'(out_data), 32'h0F);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick(1);
    end
    out_ready = 1'b1;
    send(32'h0000F00F, 3'd2, 8'hFF, 1'b0, 1'b1, 1'b0);
    drain();
    tick(2);

    // Reset with two beats in flight; they must never emerge
    out_ready = 1'b0;
    send(32'h11111111, 3'd0, 8'h11, 1'b0, 1'b0, 1'b0);
    send(32'h22222222, 3'd0, 8'h22, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick(1);
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_txn_count", 32'(txn_count), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick(6);

    // Counter wrap: 17 outputs on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      send(32'h00000000, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1);
    end
    drain();
    tick(2);
    chk("txn_count_wrap", 32'(txn_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
